// File: rtl/dual_port_ram_pkg.sv
// dual_port_ram_pkg
//   Shared constants and types for the dual-port RAM.
//   DPR_DATA_WIDTH / DPR_ADDR_WIDTH : default geometry (64 x 8)
//   word_t                          : one word at the default width
package dual_port_ram_pkg;

    localparam int DPR_DATA_WIDTH = 8;
    localparam int DPR_ADDR_WIDTH = 6;
    localparam int DPR_DEPTH      = 2 ** DPR_ADDR_WIDTH;

    typedef logic [DPR_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram
//   True dual-port synchronous RAM, one clock, two independent read/write
//   ports with registered outputs.
//
//   Ports:
//     clk            rising-edge clock for all state
//     rst            synchronous active-high reset; clears q_a/q_b only
//     data_a/b       write data per port
//     addr_a/b       word address per port (full 0..DEPTH-1 range)
//     we_a/b         1 = write (q shows the written data), 0 = read
//     q_a/b          registered read data, one cycle after the address
//
//   Same-address behaviour on one edge:
//     write on one port, read on the other -> reader sees the old word
//     both ports write                     -> port B's data is stored
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DPR_DATA_WIDTH,
    parameter int ADDR_WIDTH = DPR_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  we_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] q_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Array is deliberately left without a reset so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] q_a_q, q_a_d;
    logic [DATA_WIDTH-1:0] q_b_q, q_b_d;

    // Next output per port: own write data (write-first) or the stored word.
    // mem[] here is the pre-edge contents, which gives read-before-write
    // across ports on an address collision.
    always_comb begin
        q_a_d = mem[addr_a];
        q_b_d = mem[addr_b];
        if (we_a) q_a_d = data_a;
        if (we_b) q_b_d = data_b;
    end

    // Both ports write from one process; B's assignment comes last so it
    // wins when both ports write the same address on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_a_q <= '0;
            q_b_q <= '0;
        end else begin
            q_a_q <= q_a_d;
            q_b_q <= q_b_d;
            if (we_a) mem[addr_a] <= data_a;
            if (we_b) mem[addr_b] <= data_b;
        end
    end

    assign q_a = q_a_q;
    assign q_b = q_b_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram
//   Scoreboard bench: each cycle the expected q_a/q_b are derived from a
//   reference memory and pushed to per-port queues; after the edge they are
//   popped and compared with the DUT outputs.
module tb_dual_port_ram;
    import dual_port_ram_pkg::*;

    localparam int AW    = DPR_ADDR_WIDTH;
    localparam int DEPTH = DPR_DEPTH;

    typedef struct {
        logic  en;
        word_t v;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    word_t         data_a, data_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          we_a, we_b;
    word_t         q_a, q_b;

    dual_port_ram dut (
        .clk    (clk),
        .rst    (rst),
        .data_a (data_a),
        .addr_a (addr_a),
        .we_a   (we_a),
        .data_b (data_b),
        .addr_b (addr_b),
        .we_b   (we_b),
        .q_a    (q_a),
        .q_b    (q_b)
    );

    always #5 clk = ~clk;

    word_t ref_mem [DEPTH];
    logic  ref_vld [DEPTH];
    exp_t  sb_a[$], sb_b[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input word_t got, input word_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock of stimulus on both ports, with scoreboard push/pop.
    task automatic cyc(input string tag, input logic r,
                       input logic wa, input logic [AW-1:0] aa, input word_t da,
                       input logic wb, input logic [AW-1:0] ab, input word_t db);
        exp_t ea, eb;
        rst = r; we_a = wa; addr_a = aa; data_a = da;
        we_b = wb; addr_b = ab; data_b = db;
        if (r) begin
            ea = '{1'b1, '0};
            eb = '{1'b1, '0};
        end else begin
            ea = wa ? exp_t'{1'b1, da} : exp_t'{ref_vld[aa], ref_mem[aa]};
            eb = wb ? exp_t'{1'b1, db} : exp_t'{ref_vld[ab], ref_mem[ab]};
            if (wa) begin ref_mem[aa] = da; ref_vld[aa] = 1'b1; end
            if (wb) begin ref_mem[ab] = db; ref_vld[ab] = 1'b1; end
        end
        sb_a.push_back(ea);
        sb_b.push_back(eb);
        @(posedge clk);
        #1;
        ea = sb_a.pop_front();
        eb = sb_b.pop_front();
        if (ea.en) chk({tag, ".q_a"}, q_a, ea.v);
        if (eb.en) chk({tag, ".q_b"}, q_b, eb.v);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            ref_vld[i] = 1'b0;
        end
        rst = 1'b1; we_a = 0; we_b = 0; addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
        @(negedge clk);

        cyc("init_rst", 1, 0, 0, 8'h00, 0, 0, 8'h00);

        // Preload and leave q nonzero before reset
        cyc("pre_w", 0, 1, 5, 8'h11, 1, 6, 8'h22);
        // Reset for 2 edges with writes attempted: q clears, writes dropped
        cyc("rst1", 1, 1, 5, 8'hEE, 1, 6, 8'hDD);
        cyc("rst2", 1, 1, 5, 8'hEE, 1, 6, 8'hDD);
        cyc("post_rst", 0, 0, 5, 8'h00, 0, 6, 8'h00);   // 0x11 / 0x22

        // Parallel writes
        cyc("e1", 0, 1, 1, 8'h33, 1, 2, 8'h44);
        cyc("e2", 0, 1, 3, 8'h55, 0, 1, 8'h00);
        cyc("e3", 0, 0, 2, 8'h00, 0, 3, 8'h00);
        cyc("e4", 0, 0, 1, 8'h00, 1, 2, 8'h77);
        cyc("e5", 0, 0, 2, 8'h00, 0, 2, 8'h00);

        // Collisions at address 5 (holds 0x11)
        cyc("colA_wr", 0, 1, 5, 8'hAA, 0, 5, 8'h00);    // q_b old 0x11
        cyc("colA_rd", 0, 0, 5, 8'h00, 0, 5, 8'h00);    // both 0xAA
        cyc("col_ww",  0, 1, 5, 8'hC1, 1, 5, 8'hC2);
        cyc("col_wwrd", 0, 0, 5, 8'h00, 0, 5, 8'h00);   // both 0xC2
        cyc("colB_wr", 0, 0, 5, 8'h00, 1, 5, 8'h99);    // q_a old 0xC2
        cyc("colB_rd", 0, 0, 5, 8'h00, 0, 0, 8'h00);

        // Address extremes, read back via the opposite port
        cyc("bnd_w", 0, 1, 0, 8'hFF, 1, 63, 8'h5A);
        cyc("bnd_r", 0, 0, 63, 8'h00, 0, 0, 8'h00);

        // Random traffic on a narrow window to force frequent collisions
        for (int i = 0; i < 300; i++) begin
            cyc("rnd", ($urandom_range(0, 49) == 0),
                logic'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), word_t'($urandom),
                logic'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), word_t'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

endmodule
